bcd_serial_subtractor: RTL and testbench

BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_sub.sv | 21 ++
 rtl/bcd_serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD subtractor.
package bcd_pkg;

  localparam int BCD_W     = 4;
  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] dig);
    return dig < BCD_W'(BCD_RADIX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit subtract with borrow: d = x - y - bin, wrapped into 0..9 on borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout
);

  // x - y - bin spans -16..15, so one extra bit holds the full signed range
  logic signed [BCD_W:0] t;

  always_comb begin
    t    = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({{BCD_W{1'b0}}, bin});
    bout = t[BCD_W];
    d    = t[BCD_W-1:0] + (bout ? BCD_W'(BCD_RADIX) : '0);
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor producing sign/magnitude of a-b, LSD first.
// Define BCD_SUB_CHECK_EN to reject operands containing non-BCD digits (err=1).
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BCD_W*NDIGITS-1:0] a,
  input  logic [BCD_W*NDIGITS-1:0] b,
  output logic [BCD_W*NDIGITS-1:0] diff,
  output logic                     neg,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int W     = BCD_W * NDIGITS;
  localparam int CNT_W = $clog2(NDIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             neg_q, neg_d;
  logic [31:0]      idx;
  logic [BCD_W-1:0] x_sel, y_sel, dig_d;
  logic             dig_bout;

`ifdef BCD_SUB_CHECK_EN
  logic err_q, err_d;

  function automatic logic has_invalid(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!is_bcd_digit(v[i*BCD_W +: BCD_W])) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  assign idx = 32'(cnt_q);

  // FIX reuses the same digit subtractor as 0 - r_i - borrow
  always_comb begin
    x_sel = (state_q == FIX) ? '0 : a_q[idx*BCD_W +: BCD_W];
    y_sel = (state_q == FIX) ? res_q[idx*BCD_W +: BCD_W] : b_q[idx*BCD_W +: BCD_W];
  end

  bcd_digit_sub u_digit (
    .x    (x_sel),
    .y    (y_sel),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    neg_d    = neg_q;
`ifdef BCD_SUB_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          borrow_d = 1'b0;
          neg_d    = 1'b0;
          state_d  = SUB;
`ifdef BCD_SUB_CHECK_EN
          err_d    = 1'b0;
          if (has_invalid(a) || has_invalid(b)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      SUB, FIX: begin
        res_d[idx*BCD_W +: BCD_W] = dig_d;
        borrow_d = dig_bout;
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          borrow_d = 1'b0;
          if (state_q == FIX) begin
            neg_d   = 1'b1;
            state_d = DONE;
          end else begin
            // a final borrow means a<b: the stored digits are the ten's complement
            state_d = dig_bout ? FIX : DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      neg_q    <= neg_d;
    end
  end

`ifdef BCD_SUB_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign diff = res_q;
  assign neg  = neg_q;
  assign busy = (state_q == SUB) || (state_q == FIX);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (NDIGITS=4): vector table plus restart/reset sequences.
module tb_bcd_serial_subtractor;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] diff;
  logic         neg, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    int           lat;
  } vec_t;

  bcd_serial_subtractor #(.NDIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .neg   (neg),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start at a negedge; cycle 1 is the period after the start-sampling edge.
  task automatic run_op(input string tag, input vec_t v, input int re_cyc, input logic [W-1:0] re_a);
    int lat     = 0;
    int ndone   = 0;
    bit busy_ok = 1'b1;
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          chk({tag, " diff"}, 32'(diff), 32'(v.diff));
          chk({tag, " neg"}, 32'(neg), 32'(v.neg));
          chk({tag, " err"}, 32'(err), 32'(v.err));
        end
      end
      if (c < v.lat && busy !== 1'b1) busy_ok = 1'b0;
      if (c >= v.lat && busy !== 1'b0) busy_ok = 1'b0;
      if (lat != 0 && c == lat + 1) chk({tag, " diff hold"}, 32'(diff), 32'(v.diff));
      if (c == re_cyc) begin
        start = 1'b1;
        a     = re_a;
      end else begin
        start = 1'b0;
      end
      if (lat != 0 && c >= lat + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " done pulses"}, 32'(ndone), 32'd1);
    chk({tag, " busy profile"}, 32'(busy_ok), 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{a: 16'h0503, b: 16'h0208, diff: 16'h0295, neg: 1'b0, err: 1'b0, lat: 5};
    vecs[1] = '{a: 16'h0208, b: 16'h0503, diff: 16'h0295, neg: 1'b1, err: 1'b0, lat: 9};
    vecs[2] = '{a: 16'h0000, b: 16'h0001, diff: 16'h0001, neg: 1'b1, err: 1'b0, lat: 9};
    vecs[3] = '{a: 16'h9999, b: 16'h9999, diff: 16'h0000, neg: 1'b0, err: 1'b0, lat: 5};
    vecs[4] = '{a: 16'h1000, b: 16'h0001, diff: 16'h0999, neg: 1'b0, err: 1'b0, lat: 5};
    vecs[5] = '{a: 16'h0001, b: 16'h1000, diff: 16'h0999, neg: 1'b1, err: 1'b0, lat: 9};
    vecs[6] = '{a: 16'h9999, b: 16'h0000, diff: 16'h9999, neg: 1'b0, err: 1'b0, lat: 5};
    vecs[7] = '{a: 16'h0000, b: 16'h9999, diff: 16'h9999, neg: 1'b1, err: 1'b0, lat: 9};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {12'd0, busy, done, neg, err, diff}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 0, '0);
      @(negedge clk);
    end

    // Restart attempt mid-operation with a different minuend must be ignored
    run_op("restart", vecs[0], 2, 16'h1111);
    @(negedge clk);

    // Start held on the DONE cycle must not be accepted
    run_op("start_at_done", vecs[3], 5, 16'h1234);
    @(negedge clk);

    // Asynchronous reset in the middle of a negative-result operation
    begin
      int ndone = 0;
      a = 16'h0208;
      b = 16'h0503;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
      @(negedge clk);
      if (done === 1'b1) ndone++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort outputs", {12'd0, busy, done, neg, err, diff}, 32'd0);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done === 1'b1) ndone++;
        if (c == 2) rst_n = 1'b1;
      end
      chk("abort no done", 32'(ndone), 32'd0);
      chk("abort idle", {30'd0, busy, done}, 32'd0);
      run_op("post_reset", '{a: 16'h0010, b: 16'h0003, diff: 16'h0007, neg: 1'b0, err: 1'b0, lat: 5}, 0, '0);
      @(negedge clk);
    end

`ifdef BCD_SUB_CHECK_EN
    run_op("invalid_digit", '{a: 16'h00A3, b: 16'h0001, diff: 16'h0000, neg: 1'b0, err: 1'b1, lat: 1}, 0, '0);
    @(negedge clk);
    run_op("valid_after_err", vecs[1], 0, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
